uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single user-area UART TX pin among NREQ on-chip requesters, e.g. the hellorld message generator and the other multiplexed designs' debug printers.
- Each requester presents bytes over a valid/ready handshake.
- The arbiter grants round-robin and locks the grant to one requester until that requester flags the last byte of its message, so lines never interleave.
- It contains its own 8N1 serializer with a fixed clocks-per-bit divider.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- CLK_DIV, 5: clock cycles per UART bit, >=2. The 5 default matches the simulation bit time.
- LOCK_TIMEOUT, 1024: cycles a lock owner may leave valid low before it loses the lock. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new lock is granted. A frame in flight completes.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i].
- req_last  in  NREQ  qualifies req_data as the final byte of a message.
- req_ready  out  NREQ  per-requester accept strobe. At most one bit is high.
- txd  out  1  serial output, idle high.
- busy  out  1  high in any state other than IDLE.
- owner  out  clog2(NREQ)  index of the current or most recent lock owner.

Behaviour:
- Async reset (rst_n=0) takes effect immediately and also applies mid-frame; there is no partial stop bit. Reset values:
  - state=IDLE, txd=1, busy=0, owner=0, req_ready=0
  - rr pointer=0, lock timeout counter=0, bit and divider counters=0
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If enable and any req_valid is high, the winner is the first valid index at or after the rr pointer, scanning upward with wrap.
  - req_ready[winner] is driven combinationally high in that same cycle, the transfer occurs, and the byte, last flag and owner are registered. The next state is START.
- WAIT:
  - txd=1 and the lock is held by owner. req_ready[owner]=req_valid[owner]; no other ready is asserted. enable is ignored while locked.
  - A transfer goes to START and clears the timeout counter.
  - If there is no valid, the counter increments. When it reaches LOCK_TIMEOUT (and LOCK_TIMEOUT is nonzero), the block moves to IDLE with rr pointer=owner+1 mod NREQ.
- START: txd=0 for CLK_DIV cycles.
- DATA: 8 bits, LSB first, each held CLK_DIV cycles.
- STOP:
  - txd=1 for CLK_DIV cycles.
  - Then, if the registered last flag is set: go to IDLE and set rr pointer=owner+1 mod NREQ.
  - Otherwise: go to WAIT.
- Timing:
  - The transfer cycle T is followed by txd falling at T+1.
  - A frame lasts exactly 10*CLK_DIV cycles.
  - With valid held continuously, the frame period is 10*CLK_DIV+1 cycles (one IDLE/WAIT cycle between frames).
- Bytes are captured only on a valid&&ready transfer. req_data and req_last may change freely at any other time.
- owner holds its value in IDLE.
- A requester dropping valid mid-frame has no effect on the current frame.
- req_last on the first byte of a message means a single-byte lock.
- Divider and bit counters are sized clog2(CLK_DIV) and 4 bits. The divider wraps at CLK_DIV-1.

Test Plan:
- Single byte: CLK_DIV=5; req0 sends 0x48 with last=1 at cycle T.
  - Required: req_ready[0] high at T only; txd=0 over T+1..T+5.
  - Data bits 0,0,0,1,0,0,1,0 follow at 5 cycles each; txd=1 over T+46..T+50.
  - Then IDLE, busy=0.
- Arbitration: from reset, req1 and req2 raise valid in the same cycle, each with a one-byte message (last=1).
  - Required: req1 is granted first and its frame is transmitted.
  - req2 is granted on the cycle after req1's stop bit ends.
  - The following contention between req1 and req2 again starts searching at index 3.
- Lock: req0 streams "Hellorld!\r\n" (11 bytes, last on 0x0A) while req3 holds valid high constantly.
  - Required: the decoded txd sequence is the 11 bytes contiguous, with 51-cycle frame spacing.
  - req_ready[3] stays 0 until after the 0x0A stop bit. Repeat 5 times; there must be no byte corruption.
- Timeout: LOCK_TIMEOUT=16; req0 sends one byte with last=0, then drops valid; req1 is valid.
  - Required: WAIT persists for 16 cycles, then IDLE, then req1 is granted. owner=1.
- Enable: enable=0 with req2 valid.
  - Required: no grant and txd stays 1.
  - Dropping enable mid-frame of an unlocked owner must still complete that frame and any remaining locked message.
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - Required: txd=1 and busy=0 immediately; after release, the next grant begins from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART TX pin among NREQ byte requesters.
// Grants round-robin and keeps the grant locked to one requester until it
// sends a byte flagged last, so messages never interleave on the line.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           allows new locks to be granted (ignored while locked)
//   req_valid        per-requester byte valid
//   req_data         byte for requester i in bits [8i+7:8i]
//   req_last         marks the byte as the final one of a message
//   req_ready        per-requester accept strobe, one-hot or zero
//   txd              serial output, idle high
//   busy             high whenever the FSM is not IDLE
//   owner            current or most recent lock owner
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int CLK_DIV      = 5,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    txd,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);
    localparam int OW = $clog2(NREQ);
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = LOCK_TIMEOUT > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_byte;
    logic            r_last;
    logic [OW-1:0]   r_owner, r_rr, w_win, w_off, w_sel, w_owner_inc;
    logic [DW-1:0]   r_div;
    logic [3:0]      r_bit;
    logic [TW-1:0]   r_to, w_to_inc;
    logic [2*NREQ-1:0] w_dbl;
    logic            w_found, w_xfer, w_tick, w_timeout;

    assign w_tick      = r_div == DW'(CLK_DIV - 1);
    assign w_to_inc    = r_to + 1'b1;
    assign w_timeout   = (LOCK_TIMEOUT != 0) && (w_to_inc == TW'(LOCK_TIMEOUT));
    assign w_owner_inc = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign busy        = r_state != IDLE;
    assign owner       = r_owner;

    // Rotate valids so bit k is requester (rr+k) mod NREQ; scanning downward
    // lets the lowest set offset be the final (winning) assignment.
    always_comb begin
        w_dbl   = {req_valid, req_valid} >> r_rr;
        w_off   = '0;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_off   = OW'(k);
                w_found = 1'b1;
            end
        end
        w_win = OW'((int'(r_rr) + int'(w_off)) % NREQ);
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        txd       = 1'b1;
        w_sel     = r_owner;
        w_xfer    = 1'b0;
        case (r_state)
            IDLE: begin
                // rst_n gating keeps ready low while reset is held
                if (rst_n && enable && w_found) begin
                    req_ready[w_win] = 1'b1;
                    w_sel            = w_win;
                    w_xfer           = 1'b1;
                    w_next           = START;
                end
            end
            WAIT: begin
                req_ready[r_owner] = req_valid[r_owner];
                w_xfer             = req_valid[r_owner];
                w_next             = w_xfer ? START : (w_timeout ? IDLE : WAIT);
            end
            START: begin
                txd    = 1'b0;
                w_next = w_tick ? DATA : START;
            end
            DATA: begin
                txd    = r_byte[r_bit[2:0]];
                w_next = (w_tick && r_bit == 4'd7) ? STOP : DATA;
            end
            STOP:    w_next = w_tick ? (r_last ? IDLE : WAIT) : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_byte  <= '0;
            r_last  <= 1'b0;
            r_owner <= '0;
            r_rr    <= '0;
            r_to    <= '0;
            r_div   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_byte  <= req_data[{w_sel, 3'b000} +: 8];
                r_last  <= req_last[w_sel];
                r_owner <= w_sel;
                r_to    <= '0;
                r_div   <= '0;
                r_bit   <= '0;
            end else begin
                r_div <= (r_state == START || r_state == DATA || r_state == STOP) && !w_tick ? r_div + 1'b1 : '0;
                r_to  <= (r_state == WAIT) ? w_to_inc : '0;
                if (r_state == DATA && w_tick)
                    r_bit <= r_bit + 1'b1;
                if ((r_state == STOP && w_tick && r_last) || (r_state == WAIT && w_timeout))
                    r_rr <= w_owner_inc;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
// Ports: none (instantiates uart_tx_arbiter with NREQ=4, CLK_DIV=5, LOCK_TIMEOUT=16).
module tb_uart_tx_arbiter;
    logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0;
    logic [3:0]  req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic        txd, busy, acc_t, acc_b;
    logic [1:0]  owner;
    logic [63:0] w;
    logic [3:0]  ra;
    int          checks = 0, failures = 0;
    logic [7:0]  msg [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .CLK_DIV(5), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
        .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .txd(txd), .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setb(input int i, input logic [7:0] b, input logic l);
        req_data[8*i +: 8] = b;
        req_last[i]        = l;
    endtask

    // Expected txd over cycles T+1..T+50 after a transfer at cycle T.
    function automatic logic [63:0] frame_of(input logic [7:0] b);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < 50; k++)
            f[k] = k < 5 ? 1'b0 : (k < 45 ? b[(k - 5) / 5] : 1'b1);
        return f;
    endfunction

    task automatic capture(output logic [63:0] wf, output logic [3:0] rdy);
        wf  = '0;
        rdy = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            wf[k] = txd;
            rdy   = rdy | req_ready;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, with a request pending to show ready stays low
        enable = 1'b1;
        req_valid = 4'b0100;
        setb(2, 8'h22, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single byte 0x48
        setb(0, 8'h48, 1'b1);
        req_valid = 4'b0001;
        #1 chk("sb_ready", req_ready, 4'b0001);
        capture(w, ra);
        chk("sb_frame", w, frame_of(8'h48));
        chk("sb_quiet", ra, 0);
        req_valid = '0;
        @(negedge clk);
        #1 chk("sb_idle", {busy, txd, req_ready}, {1'b0, 1'b1, 4'b0000});

        // enable low blocks grants; a locked message still completes
        enable = 1'b0;
        setb(2, 8'h5A, 1'b0);
        req_valid = 4'b0100;
        ra = '0; acc_t = 1'b1; acc_b = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            ra = ra | req_ready; acc_t = acc_t & txd; acc_b = acc_b | busy;
        end
        chk("en_noready", ra, 0);
        chk("en_txd", acc_t, 1);
        chk("en_busy", acc_b, 0);
        enable = 1'b1;
        #1 chk("en_grant", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        enable = 1'b0;
        setb(2, 8'hA5, 1'b1);
        capture(w, ra);
        chk("en_frame1", w, frame_of(8'h5A));
        @(negedge clk);
        #1 chk("en_locked", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid = 4'b0001;
        capture(w, ra);
        chk("en_frame2", w, frame_of(8'hA5));
        ra = '0; acc_b = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            ra = ra | req_ready; acc_b = acc_b | busy;
        end
        chk("en_off_ready", ra, 0);
        chk("en_off_busy", acc_b, 0);

        // round-robin arbitration from reset
        rst_n = 1'b0;
        #1;
        enable = 1'b1;
        req_valid = 4'b0110;
        setb(1, 8'h11, 1'b1);
        setb(2, 8'h22, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arb_first", req_ready, 4'b0010);
        capture(w, ra);
        chk("arb_frame1", w, frame_of(8'h11));
        chk("arb_owner", owner, 1);
        @(negedge clk);
        #1 chk("arb_second", req_ready, 4'b0100);
        capture(w, ra);
        chk("arb_frame2", w, frame_of(8'h22));
        @(negedge clk);
        #1 chk("arb_third", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        capture(w, ra);
        chk("arb_frame3", w, frame_of(8'h11));

        // locked message vs. a constantly valid competitor
        rst_n = 1'b0;
        #1;
        req_valid = 4'b1001;
        setb(3, 8'h33, 1'b1);
        setb(0, msg[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 11; i++) begin
                #1 chk("lock_ready", req_ready, 4'b0001);
                @(posedge clk);
                #1 setb(0, msg[(i + 1) % 11], i == 9);
                capture(w, ra);
                chk("lock_byte", w, frame_of(msg[i]));
                chk("lock_quiet", ra, 0);
                @(negedge clk);
            end
            #1 chk("lock_req3", req_ready, 4'b1000);
            @(posedge clk);
            capture(w, ra);
            chk("lock_req3_frame", w, frame_of(8'h33));
            chk("lock_req3_quiet", ra, 0);
            @(negedge clk);
        end
        req_valid = '0;

        // lock timeout
        rst_n = 1'b0;
        #1;
        req_valid = 4'b0011;
        setb(0, 8'h41, 1'b0);
        setb(1, 8'h42, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("to_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = 4'b0010;
        capture(w, ra);
        chk("to_frame", w, frame_of(8'h41));
        ra = '0; acc_b = 1'b1;
        repeat (16) begin
            @(negedge clk);
            #1;
            ra = ra | req_ready; acc_b = acc_b & busy;
        end
        chk("to_wait_ready", ra, 0);
        chk("to_wait_busy", acc_b, 1);
        @(negedge clk);
        #1 chk("to_idle", {busy, req_ready}, {1'b0, 4'b0010});
        chk("to_owner_hold", owner, 0);
        @(negedge clk);
        #1 chk("to_owner", owner, 1);
        chk("to_start", txd, 0);
        req_valid = '0;
        repeat (50) @(negedge clk);

        // reset during data bit 3
        setb(2, 8'h00, 1'b1);
        req_valid = 4'b0100;
        #1 chk("mr_ready", req_ready, 4'b0100);
        repeat (22) @(posedge clk);
        #2 chk("mr_pre", {busy, txd}, 2'b10);
        rst_n = 1'b0;
        #1 chk("mr_rst", {busy, txd, req_ready}, {1'b0, 1'b1, 4'b0000});
        req_valid = 4'b0101;
        setb(0, 8'h05, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mr_rr0", req_ready, 4'b0001);
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
